// File: rtl/control_signals.sv
// -----------------------------------------------------------------------------
// control_signals
//   Shared definitions for the multi-cycle ALU and its control FSM.
//   - alu_op_t      : operation select driven by the control FSM
//   - alu_state_t   : ALU sequencer states
//   - BCD_DIGIT_MAX : largest valid decimal digit, used for the BCD carry
//                     decision and for the 9's complement of operand B
// -----------------------------------------------------------------------------
package control_signals;

  typedef enum logic [2:0] {
    OP_ADD         = 3'd0,
    OP_AND         = 3'd1,
    OP_OR          = 3'd2,
    OP_XOR         = 3'd3,
    OP_SHIFT_LEFT  = 3'd4,
    OP_SHIFT_RIGHT = 3'd5
  } alu_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } alu_state_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

endpackage

// File: rtl/alu_bcd_digit.sv
// -----------------------------------------------------------------------------
// alu_bcd_digit
//   Combinational single-digit decimal adder.
//   Ports:
//     a, b    : 4-bit digits
//     cin     : incoming decimal carry
//     invert  : use the 9's complement of b (decimal subtract)
//     digit   : resulting 4-bit digit
//     cout    : outgoing decimal carry
//   Non-BCD inputs are not flagged; they simply follow the same
//   "sum above 9 -> add 6 and carry" rule.
// -----------------------------------------------------------------------------
module alu_bcd_digit
  import control_signals::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       invert,
  output logic [3:0] digit,
  output logic       cout
);

  logic [3:0] b_eff;
  logic [4:0] sum;

  always_comb begin
    // 9 - b wraps modulo 16 for non-BCD b; the result stays deterministic.
    b_eff = invert ? (BCD_DIGIT_MAX - b) : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};
    if (sum > {1'b0, BCD_DIGIT_MAX}) begin
      digit = sum[3:0] + 4'd6;
      cout  = 1'b1;
    end else begin
      digit = sum[3:0];
      cout  = 1'b0;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle
//   Parametrised multi-cycle ALU with registered result/flags and a
//   start/busy/done handshake.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     start           : request, accepted only while busy is low
//     flush           : synchronous abort back to IDLE, no done pulse
//     operation       : ADD / AND / OR / XOR / SHIFT_LEFT / SHIFT_RIGHT
//     decimal_mode    : BCD arithmetic for ADD
//     invert_b        : complement B for ADD (~B binary, 9's complement BCD)
//     carry_in        : carry for ADD, first shift-in bit for shifts
//     input_a/input_b : operands
//     shift_amount    : shift steps, saturated to WIDTH
//     busy, done      : handshake outputs (done is a one-cycle pulse)
//     alu_out         : registered result
//     carry_out, overflow_out, zero_out, negative_out : registered flags
//
//   Every step (shift bit or BCD digit) happens on a clock edge, the first one
//   on the accept edge itself, so an L-step operation completes L-1 edges
//   after acceptance. Operations with L=1 never leave IDLE.
// -----------------------------------------------------------------------------
module alu_multicycle
  import control_signals::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               flush,
  input  alu_op_t            operation,
  input  logic               decimal_mode,
  input  logic               invert_b,
  input  logic               carry_in,
  input  logic [WIDTH-1:0]   input_a,
  input  logic [WIDTH-1:0]   input_b,
  input  logic [SHAMT_W-1:0] shift_amount,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   alu_out,
  output logic               carry_out,
  output logic               overflow_out,
  output logic               zero_out,
  output logic               negative_out
);

  localparam logic [SHAMT_W-1:0] WIDTH_S  = SHAMT_W'(WIDTH);
  localparam logic [SHAMT_W-1:0] DIGITS_S = SHAMT_W'(WIDTH / 4);
  localparam logic [SHAMT_W-1:0] ONE_S    = SHAMT_W'(1);

  // Sequencer and working registers
  alu_state_t         state_q, state_d;
  alu_op_t            op_q, op_d;
  logic               inv_q, inv_d;
  logic [WIDTH-1:0]   a_q, a_d;       // remaining BCD digits of A
  logic [WIDTH-1:0]   b_q, b_d;       // remaining BCD digits of B
  logic [WIDTH-1:0]   r_q, r_d;       // working result
  logic               c_q, c_d;       // working carry
  logic [SHAMT_W-1:0] cnt_q, cnt_d;   // steps already taken
  logic [SHAMT_W-1:0] lat_q, lat_d;   // total steps of the running op

  // Architectural outputs
  logic               done_q, done_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               cf_q, cf_d;
  logic               vf_q, vf_d;
  logic               zf_q, zf_d;
  logic               nf_q, nf_d;

  // ---------------------------------------------------------------------------
  // Step source: fresh inputs on the accept edge, working registers in RUN.
  // ---------------------------------------------------------------------------
  alu_op_t          src_op;
  logic [WIDTH-1:0] src_a, src_b, src_r;
  logic             src_c, src_inv;

  always_comb begin
    if (state_q == ST_IDLE) begin
      src_op  = operation;
      src_a   = input_a;
      src_b   = input_b;
      src_r   = input_a;
      src_c   = carry_in;
      src_inv = invert_b;
    end else begin
      src_op  = op_q;
      src_a   = a_q;
      src_b   = b_q;
      src_r   = r_q;
      src_c   = c_q;
      src_inv = inv_q;
    end
  end

  logic [3:0] bcd_digit;
  logic       bcd_cout;

  alu_bcd_digit u_bcd_digit (
    .a      (src_a[3:0]),
    .b      (src_b[3:0]),
    .cin    (src_c),
    .invert (src_inv),
    .digit  (bcd_digit),
    .cout   (bcd_cout)
  );

  // One step of the running op. Only shifts and decimal ADD ever take more
  // than one step, so the default arm is the decimal digit step: the new
  // digit enters at the top and earlier digits move down towards bit 0.
  logic [WIDTH-1:0] step_r;
  logic             step_c;

  always_comb begin
    step_r = src_r;
    step_c = src_c;
    case (src_op)
      OP_SHIFT_LEFT: begin
        step_r = {src_r[WIDTH-2:0], src_c};
        step_c = src_r[WIDTH-1];
      end
      OP_SHIFT_RIGHT: begin
        step_r = {src_c, src_r[WIDTH-1:1]};
        step_c = src_r[0];
      end
      default: begin
        step_r = (src_r >> 4) | (WIDTH'(bcd_digit) << (WIDTH - 4));
        step_c = bcd_cout;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Single-step results and latency of the requested operation.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   bin_b;
  logic [WIDTH:0]     bin_sum;
  logic               bin_v;
  logic [SHAMT_W-1:0] amt_sat;
  logic [SHAMT_W-1:0] lat_in;
  logic [WIDTH-1:0]   one_r;
  logic               one_c, one_v;
  logic               is_shift;

  always_comb begin
    bin_b    = invert_b ? ~input_b : input_b;
    bin_sum  = {1'b0, input_a} + {1'b0, bin_b} + {{WIDTH{1'b0}}, carry_in};
    bin_v    = (input_a[WIDTH-1] == bin_b[WIDTH-1]) &&
               (bin_sum[WIDTH-1] != input_a[WIDTH-1]);
    amt_sat  = (shift_amount > WIDTH_S) ? WIDTH_S : shift_amount;
    is_shift = (operation == OP_SHIFT_LEFT) || (operation == OP_SHIFT_RIGHT);

    if (is_shift) begin
      lat_in = (amt_sat == '0) ? ONE_S : amt_sat;
    end else if ((operation == OP_ADD) && decimal_mode) begin
      lat_in = DIGITS_S;
    end else begin
      lat_in = ONE_S;
    end

    one_r = input_a;
    one_c = carry_in;
    one_v = 1'b0;
    case (operation)
      OP_ADD: begin
        if (decimal_mode) begin
          one_r = step_r;
          one_c = step_c;
        end else begin
          one_r = bin_sum[WIDTH-1:0];
          one_c = bin_sum[WIDTH];
          one_v = bin_v;
        end
      end
      OP_AND: one_r = input_a & input_b;
      OP_OR:  one_r = input_a | input_b;
      OP_XOR: one_r = input_a ^ input_b;
      OP_SHIFT_LEFT, OP_SHIFT_RIGHT: begin
        if (amt_sat != '0) begin
          one_r = step_r;
          one_c = step_c;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  logic             commit_en;
  logic [WIDTH-1:0] commit_r;
  logic             commit_c, commit_v;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    inv_d     = inv_q;
    a_d       = a_q;
    b_d       = b_q;
    r_d       = r_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    done_d    = 1'b0;
    res_d     = res_q;
    cf_d      = cf_q;
    vf_d      = vf_q;
    zf_d      = zf_q;
    nf_d      = nf_q;
    commit_en = 1'b0;
    commit_r  = step_r;
    commit_c  = step_c;
    commit_v  = 1'b0;

    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_d  = operation;
            inv_d = invert_b;
            a_d   = src_a >> 4;
            b_d   = src_b >> 4;
            r_d   = step_r;
            c_d   = step_c;
            lat_d = lat_in;
            cnt_d = ONE_S;
            if (lat_in == ONE_S) begin
              commit_en = 1'b1;
              commit_r  = one_r;
              commit_c  = one_c;
              commit_v  = one_v;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          a_d = src_a >> 4;
          b_d = src_b >> 4;
          r_d = step_r;
          c_d = step_c;
          if (cnt_q == lat_q - ONE_S) begin
            commit_en = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q + ONE_S;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (commit_en) begin
      done_d = 1'b1;
      res_d  = commit_r;
      cf_d   = commit_c;
      vf_d   = commit_v;
      zf_d   = (commit_r == '0);
      nf_d   = commit_r[WIDTH-1];
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      inv_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      lat_q   <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
      cf_q    <= 1'b0;
      vf_q    <= 1'b0;
      zf_q    <= 1'b0;
      nf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      inv_q   <= inv_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      done_q  <= done_d;
      res_q   <= res_d;
      cf_q    <= cf_d;
      vf_q    <= vf_d;
      zf_q    <= zf_d;
      nf_q    <= nf_d;
    end
  end

  assign busy         = (state_q == ST_RUN);
  assign done         = done_q;
  assign alu_out      = res_q;
  assign carry_out    = cf_q;
  assign overflow_out = vf_q;
  assign zero_out     = zf_q;
  assign negative_out = nf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// -----------------------------------------------------------------------------
// tb_alu_multicycle
//   Scoreboard bench for alu_multicycle (WIDTH=8). Each accepted request pushes
//   its expected result/flags/latency; a negedge monitor pops and compares
//   whenever done is high.
// -----------------------------------------------------------------------------
module tb_alu_multicycle;
  import control_signals::*;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       v;
    logic       z;
    logic       n;
    int         lat;
    int         acc;
    int         id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       flush;
  alu_op_t    operation;
  logic       decimal_mode;
  logic       invert_b;
  logic       carry_in;
  logic [7:0] input_a;
  logic [7:0] input_b;
  logic [3:0] shift_amount;
  logic       busy;
  logic       done;
  logic [7:0] alu_out;
  logic       carry_out;
  logic       overflow_out;
  logic       zero_out;
  logic       negative_out;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         txn_id = 0;
  logic [7:0] last_r = 8'h00;
  logic       last_c = 1'b0;

  alu_multicycle #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .flush        (flush),
    .operation    (operation),
    .decimal_mode (decimal_mode),
    .invert_b     (invert_b),
    .carry_in     (carry_in),
    .input_a      (input_a),
    .input_b      (input_b),
    .shift_amount (shift_amount),
    .busy         (busy),
    .done         (done),
    .alu_out      (alu_out),
    .carry_out    (carry_out),
    .overflow_out (overflow_out),
    .zero_out     (zero_out),
    .negative_out (negative_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference model: decimal via integer arithmetic, shifts as a 9-bit rotate.
  function automatic exp_t model(input alu_op_t op, input bit dec, input bit inv,
                                 input bit cin, input logic [7:0] a,
                                 input logic [7:0] b, input logic [3:0] amt);
    exp_t e;
    logic [7:0]  eb;
    logic [8:0]  s9;
    logic [8:0]  v9;
    logic [17:0] w;
    int sa, da, db, ds, n;
    e.r = 8'h00; e.c = cin; e.v = 1'b0; e.lat = 1; e.acc = 0; e.id = 0;
    case (op)
      OP_ADD: begin
        if (dec) begin
          da = 10 * int'(a[7:4]) + int'(a[3:0]);
          db = 10 * int'(b[7:4]) + int'(b[3:0]);
          if (inv) db = 99 - db;
          ds = da + db + int'(cin);
          e.c = (ds >= 100);
          ds = ds % 100;
          e.r = 8'(((ds / 10) << 4) | (ds % 10));
          e.lat = 2;
        end else begin
          eb = inv ? ~b : b;
          s9 = 9'(a) + 9'(eb) + 9'(cin);
          e.r = s9[7:0];
          e.c = s9[8];
          sa = int'($signed(a)) + int'($signed(eb)) + int'(cin);
          e.v = (sa > 127) || (sa < -128);
        end
      end
      OP_AND: e.r = a & b;
      OP_OR:  e.r = a | b;
      OP_XOR: e.r = a ^ b;
      default: begin
        n  = (amt > 4'd8) ? 8 : int'(amt);
        v9 = {cin, a};
        if (op == OP_SHIFT_LEFT) begin
          w  = {v9, v9} << n;
          v9 = w[17:9];
        end else begin
          w  = {v9, v9} >> n;
          v9 = w[8:0];
        end
        e.r = v9[7:0];
        e.c = v9[8];
        e.lat = (n == 0) ? 1 : n;
      end
    endcase
    e.z = (e.r == 8'h00);
    e.n = e.r[7];
    return e;
  endfunction

  // Called at a negedge; holds start for one rising edge, returns at the next
  // negedge with the inputs scrambled so late sampling would be caught.
  task automatic issue(input alu_op_t op, input bit dec, input bit inv, input bit cin,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] amt, input bit acc);
    exp_t e;
    operation    = op;
    decimal_mode = dec;
    invert_b     = inv;
    carry_in     = cin;
    input_a      = a;
    input_b      = b;
    shift_amount = amt;
    start        = 1'b1;
    if (acc) begin
      e     = model(op, dec, inv, cin, a, b, amt);
      e.acc = cyc;
      e.id  = txn_id;
      txn_id++;
      sb.push_back(e);
    end
    @(negedge clk);
    start        = 1'b0;
    operation    = OP_XOR;
    decimal_mode = ~dec;
    invert_b     = ~inv;
    carry_in     = ~cin;
    input_a      = ~a;
    input_b      = b ^ 8'h5A;
    shift_amount = 4'd7;
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("t%0d.r", mon_e.id),   32'(alu_out),      32'(mon_e.r));
        check($sformatf("t%0d.c", mon_e.id),   32'(carry_out),    32'(mon_e.c));
        check($sformatf("t%0d.v", mon_e.id),   32'(overflow_out), 32'(mon_e.v));
        check($sformatf("t%0d.z", mon_e.id),   32'(zero_out),     32'(mon_e.z));
        check($sformatf("t%0d.n", mon_e.id),   32'(negative_out), 32'(mon_e.n));
        check($sformatf("t%0d.lat", mon_e.id), 32'(cyc - mon_e.acc), 32'(mon_e.lat));
        last_r = mon_e.r;
        last_c = mon_e.c;
        $display("txn %0d: r=%02h c=%0d v=%0d z=%0d n=%0d lat=%0d", mon_e.id,
                 alu_out, carry_out, overflow_out, zero_out, negative_out, cyc - mon_e.acc);
      end
    end
  end

  initial begin
    alu_op_t    rop;
    bit         rdec, rinv, rcin;
    logic [7:0] ra, rb;
    logic [3:0] ramt;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    operation = OP_ADD; decimal_mode = 1'b0; invert_b = 1'b0; carry_in = 1'b0;
    input_a = 8'h00; input_b = 8'h00; shift_amount = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out",  32'(alu_out), 32'd0);
    check("rst_flags", 32'({carry_out, overflow_out, zero_out, negative_out}), 32'd0);

    // Binary ADD, single cycle, busy never high
    issue(OP_ADD, 0, 0, 0, 8'h50, 8'h50, 4'd0, 1);
    check("add_busy", 32'(busy), 32'd0);
    check("add_done", 32'(done), 32'd1);
    wait_drain("drain_add");

    // Decimal ADD, two cycles, busy high in between
    issue(OP_ADD, 1, 0, 0, 8'h58, 8'h46, 4'd0, 1);
    check("dec_busy", 32'(busy), 32'd1);
    check("dec_done", 32'(done), 32'd0);
    wait_drain("drain_dec");
    issue(OP_ADD, 1, 1, 1, 8'h46, 8'h12, 4'd0, 1);
    wait_drain("drain_dsub1");
    issue(OP_ADD, 1, 1, 1, 8'h12, 8'h46, 4'd0, 1);
    wait_drain("drain_dsub2");

    // Shifts including zero and saturated amounts
    issue(OP_SHIFT_LEFT, 0, 0, 1, 8'h81, 8'h00, 4'd3, 1);
    wait_drain("drain_sl");
    issue(OP_SHIFT_RIGHT, 0, 0, 0, 8'h01, 8'h00, 4'd1, 1);
    wait_drain("drain_sr");
    issue(OP_SHIFT_LEFT, 0, 0, 1, 8'hC3, 8'h00, 4'd0, 1);
    wait_drain("drain_sl0");
    issue(OP_SHIFT_RIGHT, 0, 0, 1, 8'h96, 8'h00, 4'd12, 1);
    wait_drain("drain_srsat");

    // Logic ops ignore invert_b
    issue(OP_AND, 0, 1, 1, 8'hF0, 8'h3C, 4'd0, 1);
    issue(OP_OR,  0, 1, 0, 8'hF0, 8'h3C, 4'd0, 1);
    issue(OP_XOR, 0, 1, 1, 8'hAA, 8'hAA, 4'd0, 1);
    wait_drain("drain_logic");

    // Start during busy is dropped; start in the done cycle is taken
    issue(OP_ADD, 1, 0, 1, 8'h99, 8'h01, 4'd0, 1);
    issue(OP_XOR, 0, 0, 0, 8'hFF, 8'h0F, 4'd0, 0);
    check("b2b_done", 32'(done), 32'd1);
    issue(OP_OR, 0, 0, 0, 8'h12, 8'h40, 4'd0, 1);
    wait_drain("drain_b2b");

    // Flush one cycle into a 5-step shift
    issue(OP_SHIFT_LEFT, 0, 0, 1, 8'h3C, 8'h00, 4'd5, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);
    check("flush_keep_r", 32'(alu_out), 32'(last_r));
    check("flush_keep_c", 32'(carry_out), 32'(last_c));

    // Asynchronous reset in the middle of a shift
    issue(OP_ADD, 0, 0, 0, 8'h50, 8'h50, 4'd0, 1);
    wait_drain("drain_pre_rst");
    issue(OP_SHIFT_LEFT, 0, 0, 1, 8'h3C, 8'h00, 4'd5, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_out",  32'(alu_out), 32'd0);
    check("arst_flags", 32'({carry_out, overflow_out, zero_out, negative_out}), 32'd0);
    sb.delete();
    last_r = 8'h00;
    last_c = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(OP_ADD, 0, 1, 1, 8'h10, 8'h20, 4'd0, 1);
    check("post_rst_busy", 32'(busy), 32'd0);
    wait_drain("drain_post_rst");

    // Random traffic
    for (int i = 0; i < 20; i++) begin
      rop  = alu_op_t'($urandom_range(0, 5));
      rdec = 1'($urandom_range(0, 1));
      rinv = 1'($urandom_range(0, 1));
      rcin = 1'($urandom_range(0, 1));
      ramt = 4'($urandom_range(0, 15));
      if (rop == OP_ADD && rdec) begin
        ra = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end else begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
      end
      issue(rop, rdec, rinv, rcin, ra, rb, ramt, 1);
      wait_drain("drain_rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
